// File: rtl/can_bitstuff_unit_pkg.sv
// Shared types and constants for the CAN bit-stuffing engine.
package can_bitstuff_unit_pkg;

    localparam int STUFF_COUNT      = 5;
    localparam int BS_STUFF_LEN_DEF = STUFF_COUNT;

    typedef enum logic {BS_TX, BS_RX} bs_mode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STUFF = 2'd1,
        ST_ERR   = 2'd2
    } bs_state_e;

endpackage

// File: rtl/can_bitstuff_unit_if.sv
// Bit-level link between the frame FSM/serialiser and the stuffing engine.
interface can_bitstuff_unit_if;
    import can_bitstuff_unit_pkg::*;

    logic     enable;
    bs_mode_e mode;
    logic     bit_strobe;
    logic     in_bit;
    logic     in_ready;
    logic     out_bit;
    logic     out_valid;
    logic     stuff_flag;
    logic     stuff_error;

    modport master (
        output enable, mode, bit_strobe, in_bit,
        input  in_ready, out_bit, out_valid, stuff_flag, stuff_error
    );

    modport slave (
        input  enable, mode, bit_strobe, in_bit,
        output in_ready, out_bit, out_valid, stuff_flag, stuff_error
    );
endinterface

// File: rtl/bs_run_counter.sv
// Equal-bit run tracker; run_hit flags that the bit being advanced completes a run.
module bs_run_counter
    import can_bitstuff_unit_pkg::*;
#(
    parameter int STUFF_LEN = BS_STUFF_LEN_DEF,
    parameter int CNT_W     = $clog2(STUFF_LEN + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic adv,
    input  logic adv_bit,
    output logic last_bit,
    output logic run_hit
);

    localparam logic [CNT_W-1:0] LEN = CNT_W'(STUFF_LEN);

    logic             first;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = run_cnt;
        if (adv) begin
            if (first || (adv_bit != last_bit)) begin
                cnt_next = CNT_W'(1);
            end else if (run_cnt != LEN) begin
                cnt_next = run_cnt + 1'b1;
            end
        end
    end

    assign run_hit = adv && (cnt_next == LEN);

    // last_bit survives a clear; the first bit of the next frame ignores it via first
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first    <= 1'b1;
            last_bit <= 1'b1;
            run_cnt  <= '0;
        end else if (clear) begin
            first    <= 1'b1;
            run_cnt  <= '0;
        end else if (adv) begin
            first    <= 1'b0;
            last_bit <= adv_bit;
            run_cnt  <= cnt_next;
        end
    end

endmodule

// File: rtl/can_bitstuff_unit.sv
// CAN bit stuffing (TX insert) and destuffing (RX remove + stuff error), one bit per strobe.
//   state    | meaning
//   ST_RUN   | normal data slot, bits pass through and feed the run counter
//   ST_STUFF | run of STUFF_LEN reached; next slot is a stuff bit
//   ST_ERR   | RX saw no complement where a stuff bit was due; outputs silent
module can_bitstuff_unit
    import can_bitstuff_unit_pkg::*;
#(
    parameter int STUFF_LEN = BS_STUFF_LEN_DEF,
    parameter int CNT_W     = $clog2(STUFF_LEN + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    can_bitstuff_unit_if.slave   bus
);

    bs_state_e state;
    bs_state_e state_next;

    logic out_bit_q, out_bit_d;
    logic out_valid_q, out_valid_d;
    logic stuff_flag_q, stuff_flag_d;
    logic adv, adv_bit;
    logic last_bit, run_hit;
    logic is_tx;

    assign is_tx = (bus.mode == BS_TX);

    bs_run_counter #(
        .STUFF_LEN (STUFF_LEN),
        .CNT_W     (CNT_W)
    ) u_run (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (~bus.enable),
        .adv      (adv),
        .adv_bit  (adv_bit),
        .last_bit (last_bit),
        .run_hit  (run_hit)
    );

    // Bits that enter the run: every bus bit, including stuff bits, except an erroneous RX stuff slot
    always_comb begin
        adv     = 1'b0;
        adv_bit = bus.in_bit;
        if (bus.enable && bus.bit_strobe) begin
            case (state)
                ST_RUN: adv = 1'b1;
                ST_STUFF: begin
                    if (is_tx) begin
                        adv     = 1'b1;
                        adv_bit = ~last_bit;
                    end else if (bus.in_bit != last_bit) begin
                        adv = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        out_bit_d    = out_bit_q;
        out_valid_d  = 1'b0;
        stuff_flag_d = 1'b0;
        if (!bus.enable) begin
            state_next = ST_RUN;
        end else if (bus.bit_strobe) begin
            case (state)
                ST_RUN: begin
                    out_bit_d   = bus.in_bit;
                    out_valid_d = 1'b1;
                    if (run_hit) state_next = ST_STUFF;
                end
                ST_STUFF: begin
                    if (is_tx) begin
                        out_bit_d    = ~last_bit;
                        out_valid_d  = 1'b1;
                        stuff_flag_d = 1'b1;
                        state_next   = ST_RUN;
                    end else if (bus.in_bit != last_bit) begin
                        stuff_flag_d = 1'b1;
                        state_next   = ST_RUN;
                    end else begin
                        state_next   = ST_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RUN;
            out_bit_q    <= 1'b1;
            out_valid_q  <= 1'b0;
            stuff_flag_q <= 1'b0;
        end else begin
            state        <= state_next;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            stuff_flag_q <= stuff_flag_d;
        end
    end

    assign bus.out_bit     = out_bit_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.stuff_flag  = stuff_flag_q;
    assign bus.stuff_error = (state == ST_ERR);
    assign bus.in_ready    = bus.enable & is_tx & (state != ST_STUFF);

endmodule

// File: tb/tb_can_bitstuff_unit.sv
// Scoreboard bench for can_bitstuff_unit with STUFF_LEN=5 and STUFF_LEN=3 instances.
module tb_can_bitstuff_unit;
    import can_bitstuff_unit_pkg::*;

    typedef struct packed {
        logic b;
        logic v;
        logic f;
    } exp_t;

    logic     clock;
    logic     reset_n;
    logic     en5, en3, strobe, in_bit;
    bs_mode_e mode;

    int   total = 0;
    int   bad   = 0;
    exp_t q5[$];
    exp_t q3[$];

    can_bitstuff_unit_if if5 ();
    can_bitstuff_unit_if if3 ();

    assign if5.enable     = en5;
    assign if5.mode       = mode;
    assign if5.bit_strobe = strobe;
    assign if5.in_bit     = in_bit;
    assign if3.enable     = en3;
    assign if3.mode       = mode;
    assign if3.bit_strobe = strobe;
    assign if3.in_bit     = in_bit;

    can_bitstuff_unit #(.STUFF_LEN(5)) dut5 (.clock(clock), .reset_n(reset_n), .bus(if5));
    can_bitstuff_unit #(.STUFF_LEN(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(if3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic chk_s(input string name, input string got, input string exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%s required=%s", name, got, exp);
        end
    endtask

    task automatic sb_check(input int sel, input logic b, input logic v, input logic f);
        exp_t e;
        total++;
        if ((sel == 0 && q5.size() == 0) || (sel == 1 && q3.size() == 0)) begin
            bad++;
            $display("FAIL sb_len%0d unexpected event got b=%0b v=%0b f=%0b required none",
                     sel ? 3 : 5, b, v, f);
            return;
        end
        e = (sel == 0) ? q5.pop_front() : q3.pop_front();
        if (v !== e.v || f !== e.f || (e.v && b !== e.b)) begin
            bad++;
            $display("FAIL sb_len%0d got b=%0b v=%0b f=%0b required b=%0b v=%0b f=%0b",
                     sel ? 3 : 5, b, v, f, e.b, e.v, e.f);
        end
    endtask

    always @(posedge clock) begin
        if (if5.out_valid || if5.stuff_flag) sb_check(0, if5.out_bit, if5.out_valid, if5.stuff_flag);
        if (if3.out_valid || if3.stuff_flag) sb_check(1, if3.out_bit, if3.out_valid, if3.stuff_flag);
    end

    // '0'/'1' data, 'L'/'H' inserted stuff 0/1, 's' removed stuff, '-' no output
    task automatic push_exp(input int sel, input byte c);
        exp_t e;
        if (c == "-") return;
        e.b = (c == "1") || (c == "H");
        e.v = (c != "s");
        e.f = (c == "L") || (c == "H") || (c == "s");
        if (sel == 0) q5.push_back(e);
        else          q3.push_back(e);
    endtask

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) en5 = v;
        else          en3 = v;
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? if5.in_ready : if3.in_ready;
    endfunction

    task automatic send(input int sel, input bs_mode_e m, input string din,
                        input string dexp, input string rdy_exp, input string name);
        int    idx;
        logic  r;
        string seen;
        idx  = 0;
        seen = "";
        @(posedge clock);
        mode   = m;
        strobe = 1'b0;
        if (m == BS_TX) set_en(sel, 1'b1);
        for (int k = 0; k < dexp.len(); k++) begin
            @(posedge clock);
            r    = get_rdy(sel);
            seen = {seen, r ? "1" : "0"};
            if (m == BS_RX && k == 0) set_en(sel, 1'b1);
            if (m == BS_TX) in_bit = (din[(idx < din.len()) ? idx : din.len() - 1] == "1");
            else            in_bit = (din[k] == "1");
            strobe = 1'b1;
            push_exp(sel, dexp[k]);
            if (r) idx++;
        end
        @(posedge clock);
        strobe = 1'b0;
        chk_s({name, "_in_ready"}, seen, rdy_exp);
        if (m == BS_TX) chk({name, "_consumed"}, idx, din.len());
    endtask

    task automatic frame_end(input int sel);
        @(posedge clock);
        set_en(sel, 1'b0);
        @(posedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        en5     = 1'b0;
        en3     = 1'b0;
        strobe  = 1'b0;
        in_bit  = 1'b1;
        mode    = BS_TX;
        repeat (2) @(posedge clock);
        chk("rst_out_bit", if5.out_bit, 1);
        chk("rst_out_valid", if5.out_valid, 0);
        chk("rst_stuff_flag", if5.stuff_flag, 0);
        chk("rst_stuff_error", if5.stuff_error, 0);
        chk("rst_in_ready", if5.in_ready, 0);
        reset_n = 1'b1;
        @(posedge clock);

        send(0, BS_TX, "1111110", "11111L10", "11111011", "tx_ones");
        frame_end(0);
        send(0, BS_TX, "000001111", "00000H1111L", "11111011110", "tx_stuff_chain");
        frame_end(0);

        send(0, BS_RX, "0000010", "00000s0", "0000000", "rx_destuff");
        chk("rx_destuff_err", if5.stuff_error, 0);
        frame_end(0);

        send(0, BS_RX, "11111111", "11111---", "00000000", "rx_err");
        chk("rx_err_sticky", if5.stuff_error, 1);
        @(posedge clock);
        en5 = 1'b0;
        @(posedge clock);
        en5 = 1'b1;
        chk("rx_err_cleared", if5.stuff_error, 0);
        frame_end(0);

        send(0, BS_TX, "11111", "11111", "11111", "tx_pre_drop");
        chk("drop_pending_ready", if5.in_ready, 0);
        @(posedge clock);
        en5    = 1'b0;
        strobe = 1'b1;
        in_bit = 1'b1;
        @(posedge clock);
        strobe = 1'b0;
        chk("drop_out_valid", if5.out_valid, 0);
        chk("drop_stuff_flag", if5.stuff_flag, 0);
        chk("drop_out_bit_hold", if5.out_bit, 1);
        send(0, BS_TX, "111111", "11111L1", "1111101", "tx_after_drop");
        frame_end(0);

        send(1, BS_TX, "1111", "111L1", "11101", "len3_tx");
        frame_end(1);
        send(1, BS_TX, "000", "000", "111", "len3_pre_rst");
        chk("len3_pending_ready", if3.in_ready, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        en3     = 1'b0;
        #1;
        chk("len3_rst_out_bit", if3.out_bit, 1);
        chk("len3_rst_in_ready", if3.in_ready, 0);
        chk("len3_rst_out_valid", if3.out_valid, 0);
        @(posedge clock);
        reset_n = 1'b1;
        send(1, BS_TX, "0000", "000H0", "11101", "len3_after_rst");
        frame_end(1);

        repeat (3) @(posedge clock);
        chk("sb5_drained", q5.size(), 0);
        chk("sb3_drained", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/can_bitstuff_unit.md
# can_bitstuff_unit

Parametrised CAN bit-stuffing engine covering both directions in one block: in TX mode it inserts a complement stuff bit after every `STUFF_LEN` equal consecutive bits and back-pressures the frame serialiser during the inserted slot. In RX mode it removes stuff bits from the sampled bus stream and flags a stuff error when the expected complement bit is missing. It sits between the frame FSM/serialiser and the bit-timing logic, and is advanced once per bit time by the bit strobe.

## Interface
- `STUFF_LEN`, default 5: equal-bit run length that forces a stuff bit; legal range 2..15.
- `CNT_W`, default `$clog2(STUFF_LEN+1)`: run-counter width; derived, not overridden.

- `clock` in 1: bit-domain clock; all flops on falling edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: stuffing region active (SOF..CRC); low clears all run and error state.
- `mode` in 1: `BS_TX`=0, `BS_RX`=1; only changed while `enable`=0.
- `bit_strobe` in 1: one-cycle pulse per bit time; the only event that advances state.
- `in_bit` in 1: TX: next serialiser bit; RX: sampled bus bit.
- `in_ready` out 1: TX: `in_bit` is consumed at the next strobe. Combinational: `enable & ~mode & ~stuff_pending`.
- `out_bit` out 1: TX: bit to drive on the bus; RX: destuffed data bit.
- `out_valid` out 1: one-cycle pulse; `out_bit` is new this cycle. In RX it is suppressed for removed stuff bits.
- `stuff_flag` out 1: one-cycle pulse; the current strobe slot was a stuff bit, inserted in TX or removed in RX.
- `stuff_error` out 1: RX only; sticky until `enable` falls.

## Operation
- State: `last_bit`, `run_cnt[CNT_W]`, `stuff_pending`, `first` (set on enable rise), `err`.
- Reset values: `out_bit`=1 (recessive), `out_valid`=0, `stuff_flag`=0, `stuff_error`=0, `run_cnt`=0, `stuff_pending`=0, `last_bit`=1, `first`=1.
- Run update for every bit placed on or taken from the bus, stuff bits included:
  - The first bit after enable sets `run_cnt`=1.
  - Otherwise `run_cnt` becomes `run_cnt+1` if the bit equals `last_bit`, else 1.
  - `last_bit` takes the bit.
  - When the new `run_cnt`==`STUFF_LEN`, `stuff_pending` is set.
- A stuff bit starts a new run (`run_cnt`=1), so a stuff bit can itself begin the next 5-run.
- TX, strobe with `stuff_pending`=1:
  - `out_bit`=~`last_bit`, `stuff_flag`=1, `out_valid`=1.
  - `in_bit` is not consumed; `stuff_pending` clears.
- TX, strobe otherwise: `out_bit`=`in_bit`, `out_valid`=1, `stuff_flag`=0.
- RX, strobe with `stuff_pending`=1:
  - If `in_bit`≠`last_bit`: the bit is discarded, `out_valid`=0, `stuff_flag`=1.
  - If `in_bit`==`last_bit`: `err` is set, `stuff_error`=1, `out_valid`=0, and the run counter saturates at `STUFF_LEN`. No further `out_valid` pulses occur until `enable` is cycled.
- RX, strobe otherwise: `out_bit`=`in_bit`, `out_valid`=1.
- `enable`=0 (synchronous clear at the clock edge): `run_cnt`=0, `stuff_pending`=0, `first`=1, `err`=0; `out_valid`/`stuff_flag` read 0; `out_bit` holds.
- Stuff pending when `enable` falls: the stuff bit is dropped. CRC-delimiter handling belongs to the frame FSM.

## Timing
- Outputs are registered and update on the falling edge that samples `bit_strobe`=1. They hold until the next strobe; pulses last exactly one clock.
- Latency is one clock from strobe to `out_bit`/`out_valid`.
- `in_ready` falls in the same cycle `stuff_pending` sets and rises after the stuff slot's strobe edge. The serialiser holds `in_bit` stable while `in_ready`=0.
- Strobe in the same cycle `enable` falls: the clear wins and the strobe is ignored.
- Strobe in the first cycle `enable` is high: processed, with `first` semantics.
- Back-to-back strobes (every cycle) are legal.
- Reset asserted mid-frame: all state returns to reset values immediately, with no strobe required.

## Structure
- Shared package `def.pkg`: `STUFF_COUNT` stays; add `typedef enum logic {BS_TX, BS_RX} bs_mode_e` and `localparam BS_STUFF_LEN_DEF = 5`.
- Sub-module `bs_run_counter`: holds `last_bit`/`run_cnt`/`first` and emits `run_hit`. The TX/RX datapath lives in the top level.
- `can_bitstuff_unit` replaces `bitstuff_gen`/`bitstuff_chk` at the controller level.

## Test plan
- TX, `STUFF_LEN`=5, input 1,1,1,1,1,1,0 → bus 1,1,1,1,1,**0**,1,0. `in_ready` is low for exactly one strobe after the 5th bit, with `stuff_flag` on slot 6.
- TX, input 0,0,0,0,0,1,1,1,1 → bus 0,0,0,0,0,**1**,1,1,1,1,**0**. The stuff bit counts toward the next run.
- RX, bus 0,0,0,0,0,1,0 → `out_valid` on five 0s and the final 0; stuff bit removed; `stuff_error`=0.
- RX, bus 1×6 → `stuff_error`=1 at the 6th strobe and held; then `enable`=0 for one cycle → error clears.
- `STUFF_LEN`=3 build, TX 1,1,1,1 → bus 1,1,1,0,1; also `reset_n` pulsed while `stuff_pending`=1 → `out_bit`=1, `in_ready`=0 until `enable` is re-evaluated.
- `enable` falls on a strobe cycle with a stuff pending → no `out_valid`, and `run_cnt`=0 on the next enable.
